// File: rtl/eth_csr_bridge_pkg.sv
// Shared definitions for the Ethernet CSR to Avalon-MM bridge.
// Contents:
//   state_t         - bridge FSM states
//   WR_BIT / RD_BIT - request bit positions inside eth_ctrl_addr
//   RD_TIMEOUT_DATA - value returned to software when a read times out
package eth_csr_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RD_WAIT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int          WR_BIT          = 17;
  localparam int          RD_BIT          = 16;
  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/eth_csr_avmm_bridge.sv
// Bridges a level-sensitive Ethernet CSR command word onto an Avalon-MM
// master port. One transaction is issued per command; the command must be
// withdrawn (both request bits low) before another is taken. A cycle
// counter aborts transactions the slave never finishes.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   eth_ctrl_addr          - [17] write req, [16] read req, [ADDR_W-1:0] address
//   eth_wr_data            - write data
//   eth_rd_data            - last read result (all ones after a read timeout)
//   csr_busy               - a bus transaction is outstanding
//   csr_timeout            - sticky: last transaction was aborted
//   avmm_*                 - Avalon-MM master towards MAC/PHY CSR space
module eth_csr_avmm_bridge
  import eth_csr_bridge_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       eth_ctrl_addr,
  input  logic [31:0]       eth_wr_data,
  output logic [31:0]       eth_rd_data,
  output logic              csr_busy,
  output logic              csr_timeout,
  output logic [ADDR_W-1:0] avmm_address,
  output logic              avmm_read,
  output logic              avmm_write,
  output logic [31:0]       avmm_writedata,
  input  logic [31:0]       avmm_readdata,
  input  logic              avmm_readdatavalid,
  input  logic              avmm_waitrequest
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              write_r, write_s;
  logic              read_r, read_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [31:0]       rd_data_r, rd_data_s;
  logic              timeout_r, timeout_s;
  logic              busy_r, busy_s;
  logic              wr_req_s, rd_req_s, expired_s;
  logic              unused_bits_s;

  assign wr_req_s  = eth_ctrl_addr[WR_BIT];
  assign rd_req_s  = eth_ctrl_addr[RD_BIT];
  // Counter keeps running after a read is accepted, so >= guards an
  // acceptance that lands exactly on the last allowed cycle.
  assign expired_s = (cnt_r >= CNT_LAST);
  // Only the request bits and the low address bits carry meaning.
  assign unused_bits_s = ^eth_ctrl_addr;

  // Next-state, request and datapath decisions for the bridge FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    write_s   = write_r;
    read_s    = read_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    rd_data_s = rd_data_r;
    timeout_s = timeout_r;
    case (state_r)
      IDLE: begin
        if (wr_req_s || rd_req_s) begin
          timeout_s = 1'b0;
          cnt_s     = '0;
          if (wr_req_s && rd_req_s) begin
            // Conflicting command: park without touching the bus.
            state_s = HOLD;
          end else if (wr_req_s) begin
            state_s = WRITE;
            write_s = 1'b1;
            addr_s  = eth_ctrl_addr[ADDR_W-1:0];
            wdata_s = eth_wr_data;
          end else begin
            state_s = READ;
            read_s  = 1'b1;
            addr_s  = eth_ctrl_addr[ADDR_W-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (!avmm_waitrequest) begin
          write_s = 1'b0;
          state_s = HOLD;
        end else if (expired_s) begin
          write_s   = 1'b0;
          timeout_s = 1'b1;
          state_s   = HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      READ: begin
        if (!avmm_waitrequest) begin
          read_s = 1'b0;
          cnt_s  = cnt_r + CNT_ONE;
          if (avmm_readdatavalid) begin
            rd_data_s = avmm_readdata;
            state_s   = HOLD;
          end else begin
            state_s = RD_WAIT;
          end
        end else if (expired_s) begin
          read_s    = 1'b0;
          timeout_s = 1'b1;
          rd_data_s = RD_TIMEOUT_DATA;
          state_s   = HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RD_WAIT: begin
        if (avmm_readdatavalid) begin
          rd_data_s = avmm_readdata;
          state_s   = HOLD;
        end else if (expired_s) begin
          timeout_s = 1'b1;
          rd_data_s = RD_TIMEOUT_DATA;
          state_s   = HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        // Wait for the command to be withdrawn so it cannot fire twice.
        if (!wr_req_s && !rd_req_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = HOLD;
        write_s = 1'b0;
        read_s  = 1'b0;
      end
    endcase
    busy_s = (state_s == WRITE) || (state_s == READ) || (state_s == RD_WAIT);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= HOLD;
      cnt_r     <= '0;
      write_r   <= 1'b0;
      read_r    <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      rd_data_r <= 32'h0000_0000;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      write_r   <= write_s;
      read_r    <= read_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      rd_data_r <= rd_data_s;
      timeout_r <= timeout_s;
      busy_r    <= busy_s;
    end
  end

  assign avmm_write     = write_r;
  assign avmm_read      = read_r;
  assign avmm_address   = addr_r;
  assign avmm_writedata = wdata_r;
  assign eth_rd_data    = rd_data_r;
  assign csr_timeout    = timeout_r;
  assign csr_busy       = busy_r;

endmodule

// File: tb/tb_eth_csr_avmm_bridge.sv
// Self-checking bench for eth_csr_avmm_bridge: a directed vector table for
// the basic write/read/illegal-command flows, hand sequences for timeout and
// reset during a read, and randomized transactions checked cycle by cycle
// against a transaction-level expectation.
module tb_eth_csr_avmm_bridge;

  localparam int T = 16;
  localparam logic [31:0] WR = 32'h0002_0000;
  localparam logic [31:0] RD = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] eth_ctrl_addr, eth_wr_data, eth_rd_data;
  logic        csr_busy, csr_timeout;
  logic [15:0] avmm_address;
  logic        avmm_read, avmm_write;
  logic [31:0] avmm_writedata, avmm_readdata;
  logic        avmm_readdatavalid, avmm_waitrequest;

  int vectors = 0;
  int miscompares = 0;

  // Model of the software-visible/bus-visible latched values.
  logic [31:0] m_rd, m_wdata;
  logic [15:0] m_addr;
  logic        m_to;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] wdata;
    logic        wreq;
    logic        rdv;
    logic [31:0] rdata;
    logic [83:0] exp;
  } vec_t;

  vec_t tbl[22];

  always #5 clk = ~clk;

  eth_csr_avmm_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .eth_ctrl_addr(eth_ctrl_addr), .eth_wr_data(eth_wr_data),
    .eth_rd_data(eth_rd_data), .csr_busy(csr_busy), .csr_timeout(csr_timeout),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .avmm_waitrequest(avmm_waitrequest)
  );

  function automatic logic [83:0] pk(input logic w, input logic r, input logic [15:0] a,
                                     input logic [31:0] wd, input logic b, input logic t,
                                     input logic [31:0] rd);
    return {w, r, a, wd, b, t, rd};
  endfunction

  task automatic check(input string name, input logic [83:0] exp);
    logic [83:0] got;
    got = {avmm_write, avmm_read, avmm_address, avmm_writedata, csr_busy, csr_timeout, eth_rd_data};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {wr,rd,addr,wdata,busy,to,rdata}=%h expected %h", name, got, exp);
    end
  endtask

  // One complete transaction with the bench acting as a slave that holds
  // waitrequest for w request cycles and returns data d cycles after accept
  // (d < 0: never). Expectations come from the timeout rule alone.
  task automatic run_txn(input bit is_wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdat, input int w, input int d, input int extra,
                         input string name);
    int end_c, req_last;
    bit timed;
    logic [31:0] new_rd;
    eth_ctrl_addr = 32'h0000_0000;
    avmm_waitrequest = 1'b1;
    avmm_readdatavalid = 1'b0;
    @(negedge clk);
    eth_ctrl_addr = ($urandom() & 32'hFFFC_0000) | (is_wr ? WR : RD) | {16'h0000, addr};
    eth_wr_data = wd;
    req_last = (w < T) ? w : T - 1;
    if (is_wr) begin
      timed = (w >= T);
      end_c = req_last;
    end else begin
      timed = (d < 0) || (w >= T);
      end_c = timed ? T - 1 : w + d;
    end
    new_rd = is_wr ? m_rd : (timed ? 32'hFFFF_FFFF : rdat);
    m_addr = addr;
    if (is_wr) m_wdata = wd;
    m_to = 1'b0;
    for (int c = 0; c <= end_c + 1 + extra; c++) begin
      @(negedge clk);
      if (c == end_c + 1) begin
        m_to = timed;
        m_rd = new_rd;
      end
      check($sformatf("%s c%0d", name, c),
            pk(is_wr && c <= req_last, !is_wr && c <= req_last, m_addr, m_wdata,
               c <= end_c, m_to, m_rd));
      avmm_waitrequest = (c < w);
      avmm_readdata = $urandom();
      if (!is_wr && !timed && c == w + d) begin
        avmm_readdatavalid = 1'b1;
        avmm_readdata = rdat;
      end else if (is_wr || c > end_c) begin
        avmm_readdatavalid = 1'($urandom_range(0, 1));
      end else begin
        avmm_readdatavalid = 1'b0;
      end
    end
    eth_ctrl_addr = 32'h0000_0000;
  endtask

  initial begin
    reset = 1'b1;
    eth_ctrl_addr = 32'h0000_0000;
    eth_wr_data = 32'h0000_0000;
    avmm_readdata = 32'h0000_0000;
    avmm_readdatavalid = 1'b0;
    avmm_waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset", pk(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0));
    reset = 1'b0;

    tbl[0]  = '{32'h0, 32'h0, 1'b1, 1'b0, 32'h0, pk(0, 0, 16'h0000, 32'h0, 0, 0, 32'h0)};
    tbl[1]  = '{WR | 32'h0404, 32'h1234_5678, 1'b0, 1'b0, 32'h0, pk(1, 0, 16'h0404, 32'h1234_5678, 1, 0, 32'h0)};
    tbl[2]  = '{WR | 32'h0404, 32'h1234_5678, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0404, 32'h1234_5678, 0, 0, 32'h0)};
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = '{32'h0, 32'h0, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0404, 32'h1234_5678, 0, 0, 32'h0)};
    tbl[6]  = '{RD | 32'h0010, 32'h0, 1'b1, 1'b0, 32'h0, pk(0, 1, 16'h0010, 32'h1234_5678, 1, 0, 32'h0)};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = tbl[6];
    tbl[10] = '{RD | 32'h0010, 32'h0, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0010, 32'h1234_5678, 1, 0, 32'h0)};
    tbl[11] = tbl[10];
    tbl[12] = '{RD | 32'h0010, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, pk(0, 0, 16'h0010, 32'h1234_5678, 0, 0, 32'hCAFE_F00D)};
    tbl[13] = '{RD | 32'h0010, 32'h0, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0010, 32'h1234_5678, 0, 0, 32'hCAFE_F00D)};
    tbl[14] = '{32'h0, 32'h0, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0010, 32'h1234_5678, 0, 0, 32'hCAFE_F00D)};
    tbl[15] = '{WR | RD | 32'h0055, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h0010, 32'h1234_5678, 0, 0, 32'hCAFE_F00D)};
    tbl[16] = tbl[15];
    tbl[17] = tbl[14];
    tbl[18] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_2222, pk(0, 0, 16'h0010, 32'h1234_5678, 0, 0, 32'hCAFE_F00D)};
    tbl[19] = '{WR | 32'h00AA, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, pk(1, 0, 16'h00AA, 32'hA5A5_5A5A, 1, 0, 32'hCAFE_F00D)};
    tbl[20] = '{32'h0, 32'h0, 1'b0, 1'b0, 32'h0, pk(0, 0, 16'h00AA, 32'hA5A5_5A5A, 0, 0, 32'hCAFE_F00D)};
    tbl[21] = tbl[20];

    for (int i = 0; i < 22; i++) begin
      eth_ctrl_addr = tbl[i].ctrl;
      eth_wr_data = tbl[i].wdata;
      avmm_waitrequest = tbl[i].wreq;
      avmm_readdatavalid = tbl[i].rdv;
      avmm_readdata = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    m_rd = 32'hCAFE_F00D;
    m_wdata = 32'hA5A5_5A5A;
    m_addr = 16'h00AA;
    m_to = 1'b0;

    // Read whose data never returns, then a write that clears the flag.
    run_txn(1'b0, 16'h0020, 32'h0, 32'h0, 0, -1, 1, "rd_timeout");
    run_txn(1'b1, 16'h0404, 32'h0BAD_BEEF, 32'h0, 0, 0, 1, "wr_after_timeout");

    // Reset while a read is stalled and its command stays asserted.
    eth_ctrl_addr = 32'h0000_0000;
    avmm_waitrequest = 1'b1;
    avmm_readdatavalid = 1'b0;
    @(negedge clk);
    eth_ctrl_addr = RD | 32'h0030;
    @(negedge clk);
    check("rst_rd_issue", pk(0, 1, 16'h0030, m_wdata, 1, 0, m_rd));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rd_drop", pk(0, 0, 16'h0000, 32'h0, 0, 0, 32'h0));
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_reissue%0d", k), pk(0, 0, 16'h0000, 32'h0, 0, 0, 32'h0));
    end
    eth_ctrl_addr = 32'h0000_0000;
    @(negedge clk);
    check("rst_release", pk(0, 0, 16'h0000, 32'h0, 0, 0, 32'h0));
    eth_ctrl_addr = RD | 32'h0030;
    @(negedge clk);
    check("rst_reissue", pk(0, 1, 16'h0030, 32'h0, 1, 0, 32'h0));
    avmm_waitrequest = 1'b0;
    avmm_readdatavalid = 1'b1;
    avmm_readdata = 32'h5A5A_0001;
    @(negedge clk);
    check("rst_reissue_done", pk(0, 0, 16'h0030, 32'h0, 0, 0, 32'h5A5A_0001));
    eth_ctrl_addr = 32'h0000_0000;
    m_rd = 32'h5A5A_0001;
    m_addr = 16'h0030;
    m_wdata = 32'h0;
    m_to = 1'b0;

    // Randomized transactions; completion indices never land exactly on
    // the last counter value, where timeout and completion coincide.
    for (int n = 0; n < 40; n++) begin
      bit is_wr;
      int w, d;
      is_wr = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 21)) : int'($urandom_range(0, 6));
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 5));
      run_txn(is_wr, 16'($urandom()), $urandom(), $urandom(), w, d,
              int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
